// File: rtl/lut_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_check_pkg
// Description : Shared types and sizes for the LUT INIT self-test sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package lut_check_pkg;

    localparam int LUT_INPUTS = 4;
    localparam int LUT_BITS   = 16;
    localparam int MISMATCH_W = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lut_check_popcount.sv
`default_nettype none
// ============================================================================
// Module      : lut_check_popcount
// Description : Combinational population count of a truth-table-wide vector.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_check_popcount
    import lut_check_pkg::*;
(
    input  logic [LUT_BITS-1:0]   vec_i,
    output logic [MISMATCH_W-1:0] count_o
);

    // Sum the set bits; a 16-bit vector needs 5 bits to hold a count of 16.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < LUT_BITS; i++) begin
            count_o = count_o + MISMATCH_W'(vec_i[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lut_init_checker.sv
`default_nettype none
// ============================================================================
// Module      : lut_init_checker
// Description : Sweeps a 4-input LUT through all 16 select codes, captures the
//               returned output per code and compares the captured truth
//               table against the expected INIT.
//               Optional macro LUT_CHECK_LOOP_EN: sweeps repeat forever after
//               the first start, and pass becomes sticky-low until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_init_checker
    import lut_check_pkg::*;
#(
    parameter logic [LUT_BITS-1:0] INIT   = 16'h000E,
    parameter int                  SETTLE = 1
)(
    input  logic                    C,
    input  logic                    R,
    input  logic                    start,
    output logic [LUT_INPUTS-1:0]   lut_a,
    input  logic                    lut_o,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [LUT_BITS-1:0]     captured,
    output logic [MISMATCH_W-1:0]   mismatches
);

    // Last settle count value before sampling (SETTLE is 1..15).
    localparam logic [LUT_INPUTS-1:0] c_SETTLE_LAST = LUT_INPUTS'(SETTLE - 1);

    state_t                  state_q;
    logic [LUT_INPUTS-1:0]   index_q;
    logic [LUT_INPUTS-1:0]   settle_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic [LUT_BITS-1:0]     captured_q;
    logic [MISMATCH_W-1:0]   mismatches_q;
    logic [MISMATCH_W-1:0]   w_count;
    logic                    w_go;
`ifdef LUT_CHECK_LOOP_EN
    logic                    fail_seen_q;
`endif

    // Launch condition: a start request in IDLE; in DONE either start or,
    // in loop mode, an unconditional restart.
`ifdef LUT_CHECK_LOOP_EN
    assign w_go = (state_q == IDLE) ? start : 1'b1;
`else
    assign w_go = start;
`endif

    lut_check_popcount u_popcount (
        .vec_i   (captured_q ^ INIT),
        .count_o (w_count)
    );

    // Sweep sequencer: drive code, wait SETTLE cycles, sample, then judge.
    always_ff @(posedge C) begin
        if (!R) begin
            state_q      <= IDLE;
            index_q      <= '0;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            captured_q   <= '0;
            mismatches_q <= '0;
`ifdef LUT_CHECK_LOOP_EN
            fail_seen_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (w_go) begin
                        index_q    <= '0;
                        settle_q   <= '0;
                        captured_q <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    settle_q <= settle_q + 1'b1;
                    if (settle_q == c_SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    captured_q[index_q] <= lut_o;
                    if (index_q == 4'hF) begin
                        // Code 15 is the last one; lut_a stays on 15 from here.
                        state_q <= CHECK;
                    end else begin
                        index_q  <= index_q + 1'b1;
                        settle_q <= '0;
                        state_q  <= DRIVE;
                    end
                end
                CHECK: begin
                    mismatches_q <= w_count;
`ifdef LUT_CHECK_LOOP_EN
                    pass_q       <= (w_count == '0) && !fail_seen_q;
                    fail_seen_q  <= fail_seen_q | (w_count != '0);
`else
                    pass_q       <= (w_count == '0);
`endif
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lut_a      = index_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign captured   = captured_q;
    assign mismatches = mismatches_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_init_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_init_checker
// Description : Self-checking bench for lut_init_checker. Two instances share
//               one clock: a combinational LUT model (SETTLE=1) and a
//               registered two-stage LUT model (SETTLE=3).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lut_init_checker;

    localparam logic [15:0] INIT0   = 16'h000E;
    localparam logic [15:0] INIT1   = 16'hA5C3;
    localparam int          SETTLE0 = 1;
    localparam int          SETTLE1 = 3;
    // done rises 16*(SETTLE+1)+2 cycles after the start edge
    localparam int          LAT0    = 16 * (SETTLE0 + 1) + 2;
    localparam int          LAT1    = 16 * (SETTLE1 + 1) + 2;
    localparam int          BOUND   = 400;

    logic        C = 1'b0;
    logic        R;
    logic        start0, start1;
    logic [3:0]  lut_a0, lut_a1;
    logic        lut_o0, lut_o1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0] cap0, cap1;
    logic [4:0]  mm0, mm1;
    logic [15:0] tt0, tt1;
    logic        pipe_a, pipe_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 C = ~C;

    // LUT models: truth table tt indexed by the select code.
    assign lut_o0 = tt0[lut_a0];
    always @(posedge C) begin
        pipe_a <= tt1[lut_a1];
        pipe_b <= pipe_a;
    end
    assign lut_o1 = pipe_b;

    lut_init_checker #(.INIT(INIT0), .SETTLE(SETTLE0)) u_dut0 (
        .C(C), .R(R), .start(start0), .lut_a(lut_a0), .lut_o(lut_o0),
        .busy(busy0), .done(done0), .pass(pass0), .captured(cap0), .mismatches(mm0)
    );

    lut_init_checker #(.INIT(INIT1), .SETTLE(SETTLE1)) u_dut1 (
        .C(C), .R(R), .start(start1), .lut_a(lut_a1), .lut_o(lut_o1),
        .busy(busy1), .done(done1), .pass(pass1), .captured(cap1), .mismatches(mm1)
    );

    // Reference: number of truth-table positions that disagree.
    function automatic int diff_bits(input logic [15:0] a, input logic [15:0] b);
        int c;
        c = 0;
        for (int k = 0; k < 16; k++) begin
            if (a[k] != b[k]) c++;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Pulse start for one edge, then wait (bounded) for done. n is the cycle
    // in which done was first seen, counted from the start edge.
    task automatic run_sweep(input int which, output int n,
                             output logic b_first, output logic [3:0] a_first);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        n = 1;
        b_first = (which == 0) ? busy0 : busy1;
        a_first = (which == 0) ? lut_a0 : lut_a1;
        while (((which == 0) ? done0 : done1) !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        R = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) tick();
        n_total++; if ({lut_a0, busy0, done0, pass0} !== 7'd0) $display("FAIL reset_ctrl0 got %b want 0", {lut_a0, busy0, done0, pass0}); else n_pass++;
        n_total++; if (cap0 !== 16'h0) $display("FAIL reset_cap0 got %h want 0000", cap0); else n_pass++;
        n_total++; if (mm0 !== 5'd0) $display("FAIL reset_mm0 got %0d want 0", mm0); else n_pass++;
        n_total++; if ({lut_a1, busy1, done1, pass1, cap1, mm1} !== 28'd0) $display("FAIL reset_dut1 got %h want 0", {lut_a1, busy1, done1, pass1, cap1, mm1}); else n_pass++;
        R = 1'b1;
        tick();
    endtask

    task automatic test_match();
        int n; logic b; logic [3:0] a;
        tt0 = INIT0;
        run_sweep(0, n, b, a);
        n_total++; if (b !== 1'b1 || a !== 4'd0) $display("FAIL match_first_cycle busy=%b lut_a=%0d want busy=1 lut_a=0", b, a); else n_pass++;
        n_total++; if (n !== LAT0) $display("FAIL match_latency got %0d want %0d", n, LAT0); else n_pass++;
        n_total++; if (pass0 !== 1'b1) $display("FAIL match_pass got %b want 1", pass0); else n_pass++;
        n_total++; if (cap0 !== INIT0) $display("FAIL match_cap got %h want %h", cap0, INIT0); else n_pass++;
        n_total++; if (mm0 !== 5'd0) $display("FAIL match_mm got %0d want 0", mm0); else n_pass++;
        n_total++; if (busy0 !== 1'b0 || lut_a0 !== 4'd15) $display("FAIL match_done_state busy=%b lut_a=%0d want busy=0 lut_a=15", busy0, lut_a0); else n_pass++;
        tick();
        n_total++; if (done0 !== 1'b1) $display("FAIL match_done_held got %b want 1", done0); else n_pass++;
    endtask

    task automatic test_mismatch();
        int n; logic b; logic [3:0] a;
        tt0 = 16'h000F;
        run_sweep(0, n, b, a);
        n_total++; if (n !== LAT0) $display("FAIL mis_latency got %0d want %0d", n, LAT0); else n_pass++;
        n_total++; if (pass0 !== 1'b0) $display("FAIL mis_pass got %b want 0", pass0); else n_pass++;
        n_total++; if (cap0 !== 16'h000F) $display("FAIL mis_cap got %h want 000f", cap0); else n_pass++;
        n_total++; if (mm0 !== 5'd1) $display("FAIL mis_mm got %0d want 1", mm0); else n_pass++;
    endtask

    task automatic test_random();
        int n; logic b; logic [3:0] a;
        for (int i = 0; i < 8; i++) begin
            if (i == 0)          tt0 = ~INIT0;
            else if (i % 3 == 0) tt0 = INIT0 ^ (16'h1 << $urandom_range(15));
            else                 tt0 = 16'($urandom);
            run_sweep(0, n, b, a);
            n_total++; if (cap0 !== tt0) $display("FAIL rand_cap[%0d] got %h want %h", i, cap0, tt0); else n_pass++;
            n_total++; if (mm0 !== 5'(diff_bits(tt0, INIT0))) $display("FAIL rand_mm[%0d] got %0d want %0d", i, mm0, diff_bits(tt0, INIT0)); else n_pass++;
            n_total++; if (pass0 !== (tt0 == INIT0)) $display("FAIL rand_pass[%0d] got %b want %b", i, pass0, tt0 == INIT0); else n_pass++;
        end
    endtask

    task automatic test_settle3();
        int n; logic b; logic [3:0] a;
        tt1 = INIT1;
        run_sweep(1, n, b, a);
        n_total++; if (n !== LAT1) $display("FAIL s3_latency got %0d want %0d", n, LAT1); else n_pass++;
        n_total++; if (pass1 !== 1'b1 || cap1 !== INIT1) $display("FAIL s3_match pass=%b cap=%h want pass=1 cap=%h", pass1, cap1, INIT1); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tt1 = 16'($urandom);
            run_sweep(1, n, b, a);
            n_total++; if (cap1 !== tt1) $display("FAIL s3_rand_cap[%0d] got %h want %h", i, cap1, tt1); else n_pass++;
            n_total++; if (mm1 !== 5'(diff_bits(tt1, INIT1)) || pass1 !== (tt1 == INIT1)) $display("FAIL s3_rand_res[%0d] mm=%0d pass=%b want mm=%0d pass=%b", i, mm1, pass1, diff_bits(tt1, INIT1), tt1 == INIT1); else n_pass++;
        end
    endtask

    task automatic test_reset_midsweep();
        int n; logic b; logic [3:0] a;
        tt0 = 16'h000F;
        run_sweep(0, n, b, a);
        tt0 = INIT0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 1;
        while (n < 20) begin tick(); n++; end
        // reset and start together: reset must win
        R = 1'b0;
        start0 = 1'b1;
        tick();
        n_total++; if ({lut_a0, busy0, done0, pass0} !== 7'd0) $display("FAIL midrst_ctrl got %b want 0", {lut_a0, busy0, done0, pass0}); else n_pass++;
        n_total++; if (cap0 !== 16'h0 || mm0 !== 5'd0) $display("FAIL midrst_data cap=%h mm=%0d want 0000 0", cap0, mm0); else n_pass++;
        R = 1'b1;
        start0 = 1'b0;
        tick();
        n_total++; if (busy0 !== 1'b0) $display("FAIL midrst_idle busy got %b want 0", busy0); else n_pass++;
        run_sweep(0, n, b, a);
        n_total++; if (n !== LAT0 || pass0 !== 1'b1) $display("FAIL midrst_resweep n=%0d pass=%b want %0d 1", n, pass0, LAT0); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int n;
        tt0 = INIT0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 1;
        while (done0 !== 1'b1 && n < BOUND) begin
            start0 = (n == 10);
            tick();
            n++;
        end
        start0 = 1'b0;
        n_total++; if (n !== LAT0) $display("FAIL busy_start latency got %0d want %0d", n, LAT0); else n_pass++;
        repeat (3) tick();
        n_total++; if (done0 !== 1'b1 || busy0 !== 1'b0) $display("FAIL busy_start_idle done=%b busy=%b want 1 0", done0, busy0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n;
        tt0 = INIT0;
        start0 = 1'b1;
        tick();
        n = 1;
        while (done0 !== 1'b1 && n < BOUND) begin tick(); n++; end
        n_total++; if (n !== LAT0) $display("FAIL b2b_first latency got %0d want %0d", n, LAT0); else n_pass++;
        tick();
        n_total++; if (done0 !== 1'b0 || busy0 !== 1'b1 || lut_a0 !== 4'd0) $display("FAIL b2b_restart done=%b busy=%b lut_a=%0d want 0 1 0", done0, busy0, lut_a0); else n_pass++;
        n = 1;
        start0 = 1'b0;
        while (done0 !== 1'b1 && n < BOUND) begin tick(); n++; end
        n_total++; if (n !== LAT0 || pass0 !== 1'b1) $display("FAIL b2b_second n=%0d pass=%b want %0d 1", n, pass0, LAT0); else n_pass++;
    endtask

`ifdef LUT_CHECK_LOOP_EN
    task automatic test_loop();
        int n; logic b; logic [3:0] a;
        tt0 = ~INIT0;
        run_sweep(0, n, b, a);
        n_total++; if (n !== LAT0 || mm0 !== 5'd16 || pass0 !== 1'b0) $display("FAIL loop_sweep1 n=%0d mm=%0d pass=%b want %0d 16 0", n, mm0, pass0, LAT0); else n_pass++;
        tt0 = INIT0;
        tick();
        n_total++; if (done0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL loop_restart done=%b busy=%b want 0 1", done0, busy0); else n_pass++;
        n = 1;
        while (done0 !== 1'b1 && n < BOUND) begin tick(); n++; end
        n_total++; if (n !== LAT0 || mm0 !== 5'd0 || pass0 !== 1'b0) $display("FAIL loop_sweep2 n=%0d mm=%0d pass=%b want %0d 0 0", n, mm0, pass0, LAT0); else n_pass++;
    endtask
`endif

    initial begin
        R = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        tt0 = 16'h0;
        tt1 = 16'h0;
        tick();
        test_reset();
`ifdef LUT_CHECK_LOOP_EN
        test_loop();
`else
        test_match();
        test_mismatch();
        test_random();
        test_settle3();
        test_reset_midsweep();
        test_start_while_busy();
        test_back_to_back();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
